// File: rtl/prio_grant_ctrl.sv
// rtl/prio_grant_ctrl.sv - priority arbiter with starvation promotion, hold timeout and release gap
//
// Purpose: grants one of N requesters at a time. The lowest effective priority
// wins (0 is highest) and ties go to the lowest index. A requester that has
// lost MAX_WAIT arbitrations in a row is promoted to effective priority 0.
// A grant lasts until rel_i, until the grantee drops its request, or until
// MAX_HOLD cycles have elapsed. Every release is followed by one idle GAP cycle.
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset
//   req_i      - per-requester request level
//   prio_i     - packed priorities, requester k at [k*PRIO_BITS +: PRIO_BITS]
//   rel_i      - release strobe from the current grantee
//   gnt_o      - one-hot grant
//   gnt_vld_o  - a grant is active
//   sel_o      - index of the grantee, held after release
//   prio_o     - raw priority of the grantee captured at grant time, held after release
//   timeout_o  - one-cycle pulse in GAP when the grant was revoked by the hold limit
module prio_grant_ctrl #(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_HOLD  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N-1:0]           req_i,
    input  logic [N*PRIO_BITS-1:0] prio_i,
    input  logic                   rel_i,
    output logic [N-1:0]           gnt_o,
    output logic                   gnt_vld_o,
    output logic [$clog2(N)-1:0]   sel_o,
    output logic [PRIO_BITS-1:0]   prio_o,
    output logic                   timeout_o
);

    localparam int SW = $clog2(N);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [N-1:0]         gnt_q, gnt_d;
    logic                 vld_q, vld_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [PRIO_BITS-1:0] prio_q, prio_d;
    logic                 timeout_q, timeout_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [WW-1:0]        wait_q [N];

    logic                 grant_entry;
    logic                 release_now;
    logic                 best_found;
    logic [SW-1:0]        best_idx;
    logic [PRIO_BITS-1:0] best_eff;
    logic [PRIO_BITS-1:0] best_raw;
    logic [PRIO_BITS-1:0] eff;
    logic [PRIO_BITS-1:0] raw;

    // Strict "<" while scanning upward keeps the lowest index on ties.
    always_comb begin
        best_found = 1'b0;
        best_idx   = '0;
        best_eff   = '0;
        best_raw   = '0;
        eff        = '0;
        raw        = '0;
        for (int k = 0; k < N; k++) begin
            raw = prio_i[k*PRIO_BITS +: PRIO_BITS];
            eff = (wait_q[k] == WW'(MAX_WAIT)) ? '0 : raw;
            if (req_i[k] && (!best_found || (eff < best_eff))) begin
                best_found = 1'b1;
                best_idx   = SW'(k);
                best_eff   = eff;
                best_raw   = raw;
            end
        end
    end

    assign release_now = rel_i || !req_i[sel_q] || (hold_q == HW'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        vld_d       = vld_q;
        sel_d       = sel_q;
        prio_d      = prio_q;
        hold_d      = hold_q;
        timeout_d   = 1'b0;
        grant_entry = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                gnt_d = '0;
                vld_d = 1'b0;
                if (|req_i) begin
                    state_d     = GRANT;
                    grant_entry = 1'b1;
                    gnt_d       = N'(1) << best_idx;
                    vld_d       = 1'b1;
                    sel_d       = best_idx;
                    prio_d      = best_raw;
                    hold_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    vld_d     = 1'b0;
                    hold_d    = '0;
                    // rel_i and a dropped request take precedence over the hold limit
                    timeout_d = !rel_i && req_i[sel_q];
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            vld_q     <= 1'b0;
            sel_q     <= '0;
            prio_q    <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            vld_q     <= vld_d;
            sel_q     <= sel_d;
            prio_q    <= prio_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    // Wait counters only move on grant entry: the winner and idle requesters
    // restart, losers that are still asking age toward promotion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N; k++) begin
                wait_q[k] <= '0;
            end
        end else if (grant_entry) begin
            for (int k = 0; k < N; k++) begin
                if (SW'(k) == best_idx || !req_i[k]) begin
                    wait_q[k] <= '0;
                end else if (wait_q[k] != WW'(MAX_WAIT)) begin
                    wait_q[k] <= wait_q[k] + WW'(1);
                end
            end
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_vld_o = vld_q;
    assign sel_o     = sel_q;
    assign prio_o    = prio_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_prio_grant_ctrl.sv
// tb/tb_prio_grant_ctrl.sv - directed self-checking bench for prio_grant_ctrl
module tb_prio_grant_ctrl;

    localparam int N  = 8;
    localparam int PB = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*PB-1:0] prio;
    logic          rel;
    logic [N-1:0]  gnt;
    logic          gnt_vld;
    logic [2:0]    sel;
    logic [PB-1:0] prio_out;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    int cnt;

    prio_grant_ctrl #(.N(N), .PRIO_BITS(PB), .MAX_WAIT(4), .MAX_HOLD(16)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .prio_i    (prio),
        .rel_i     (rel),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .sel_o     (sel),
        .prio_o    (prio_out),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int k, input int p);
        prio[k*PB +: PB] = PB'(p);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        prio  = '0;
        rel   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_vld", 32'(gnt_vld), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_vld", 32'(gnt_vld), 32'h0);

        // priority pick: req 2 (prio 5) vs req 5 (prio 1)
        req = 8'b0010_0100;
        set_prio(2, 5);
        set_prio(5, 1);
        tick();
        check("pick_gnt", 32'(gnt), 32'h20);
        check("pick_sel", 32'(sel), 32'd5);
        check("pick_prio", 32'(prio_out), 32'd1);
        check("pick_vld", 32'(gnt_vld), 32'h1);
        tick();
        check("hold_gnt", 32'(gnt), 32'h20);
        // grantee drops its request mid-grant
        req = 8'b0000_0000;
        tick();
        check("drop_gnt", 32'(gnt), 32'h0);
        check("drop_timeout", 32'(timeout), 32'h0);
        check("drop_sel_kept", 32'(sel), 32'd5);
        tick();
        check("idle_prio_kept", 32'(prio_out), 32'd1);

        // equal priorities: lowest index first, then the other after a gap
        prio = '0;
        set_prio(1, 3);
        set_prio(6, 3);
        req = 8'b0100_0010;
        tick();
        check("tie_sel", 32'(sel), 32'd1);
        rel = 1'b1;
        req = 8'b0100_0000;
        tick();
        rel = 1'b0;
        check("gap_vld", 32'(gnt_vld), 32'h0);
        check("gap_sel_kept", 32'(sel), 32'd1);
        tick();
        check("second_sel", 32'(sel), 32'd6);
        check("second_gnt", 32'(gnt), 32'h40);
        req = '0;
        tick();
        tick();

        // starvation: req 0 (prio 1) keeps winning until req 7 (prio 7) is promoted
        prio = '0;
        set_prio(0, 1);
        set_prio(7, 7);
        req = 8'b1000_0001;
        for (int a = 1; a <= 5; a++) begin
            tick();
            check($sformatf("starve_arb%0d", a), 32'(sel), (a == 5) ? 32'd7 : 32'd0);
            rel = 1'b1;
            tick();
            rel = 1'b0;
        end
        req = '0;
        tick();

        // hold limit: single requester never releases
        prio = '0;
        req  = 8'b0000_1000;
        tick();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!gnt_vld) break;
            cnt++;
            check("to_no_early_pulse", 32'(timeout), 32'h0);
            tick();
        end
        check("to_hold_cycles", 32'(cnt), 32'd16);
        check("to_pulse", 32'(timeout), 32'h1);
        tick();
        check("to_regrant", 32'(gnt_vld), 32'h1);
        check("to_pulse_once", 32'(timeout), 32'h0);
        check("to_regrant_sel", 32'(sel), 32'd3);
        // rel_i on the same cycle the hold limit fires counts as a normal release
        repeat (15) tick();
        check("to_still_held", 32'(gnt_vld), 32'h1);
        rel = 1'b1;
        req = '0;
        tick();
        rel = 1'b0;
        check("rel_and_to_vld", 32'(gnt_vld), 32'h0);
        check("rel_and_to_timeout", 32'(timeout), 32'h0);
        tick();

        // asynchronous reset in the middle of a grant
        req = 8'b0001_0000;
        tick();
        check("pre_rst_vld", 32'(gnt_vld), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'h0);
        check("async_vld", 32'(gnt_vld), 32'h0);
        check("async_sel", 32'(sel), 32'h0);
        check("async_prio", 32'(prio_out), 32'h0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_vld", 32'(gnt_vld), 32'h1);
        check("post_rst_sel", 32'(sel), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
